imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, is the byte address of the first instruction word written.
REQ-002 Parameter MAX_WORDS, default 1024, is the largest word count accepted; it equals the instruction-memory depth.
REQ-003 clk  input  1  Sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  Synchronous, active-high reset.
REQ-005 start_i  input  1  Begin a load session; sampled only in IDLE, DONE or ERROR.
REQ-006 byte_valid_i  input  1  byte_data_i holds a valid stream byte.
REQ-007 byte_data_i  input  8  Stream byte.
REQ-008 byte_ready_o  output  1  Loader accepts a byte this cycle; a transfer occurs when valid and ready are both 1.
REQ-009 addr_imem_ram_o  output  32  Instruction-memory write byte address, word-aligned.
REQ-010 wr_instr_imem_ram_o  output  32  Instruction word to write.
REQ-011 wr_en_imem_ram_o  output  1  Single-cycle write strobe to instruction memory.
REQ-012 busy_o  output  1  Session in progress; the core is held off instruction fetch while 1.
REQ-013 done_o  output  1  Last session completed successfully.
REQ-014 error_o  output  1  Last session rejected: header count exceeded MAX_WORDS.
REQ-015 words_written_o  output  11  Words written in the current or last session.

Function
REQ-016 Stream format: 4-byte little-endian header N (word count), then N words, each 4 bytes little-endian (first byte = bits 7:0).
REQ-017 The FSM states shall be IDLE, HDR, DATA, WRITE, DONE and ERROR.
REQ-018 IDLE/DONE/ERROR: start_i=1 -> HDR next cycle; clear byte counter, words_written_o, done_o and error_o; set address to BASE_ADDR.
REQ-019 start_i while busy_o=1 shall be ignored.
REQ-020 byte_ready_o shall be 1 only in HDR and DATA; it is 0 in IDLE, WRITE, DONE and ERROR.
REQ-021 A 2-bit byte counter shall place each accepted byte into lane [8*cnt+7:8*cnt] of a 32-bit assembly register and then increment, wrapping 3->0.
REQ-022 HDR: on the 4th accepted byte, N is the full assembled value; N=0 -> DONE; N>MAX_WORDS -> ERROR; otherwise -> DATA.
REQ-023 The N comparison shall use all 32 bits; upper bits of N shall not be truncated.
REQ-024 DATA: on the 4th accepted byte -> WRITE next cycle; wr_instr_imem_ram_o shall hold the assembled word.
REQ-025 WRITE lasts exactly one cycle, with wr_en_imem_ram_o=1 and addr_imem_ram_o = current address.
REQ-026 After WRITE, the address shall increment by 4 and words_written_o by 1.
REQ-027 After WRITE, the FSM -> DONE if words_written_o (after increment) equals N, else -> DATA.
REQ-028 wr_en_imem_ram_o shall be 0 in every state other than WRITE.
REQ-029 addr_imem_ram_o[1:0] shall always be 2'b00.
REQ-030 Address arithmetic is 32-bit and wraps modulo 2^32.
REQ-031 Per-word latency: the strobe occurs exactly 1 cycle after the word's 4th byte is accepted.
REQ-032 Byte-valid gaps (valid=0) shall stall assembly without losing state.
REQ-033 busy_o = 1 in HDR, DATA and WRITE; done_o = 1 only in DONE; error_o = 1 only in ERROR.
REQ-034 In ERROR, no write shall occur and remaining stream bytes are not consumed.

Reset
REQ-035 reset=1 at a clock edge -> next cycle: IDLE, all outputs 0, counters 0, address BASE_ADDR.
REQ-036 Reset takes priority over start_i and over any in-flight transfer.
REQ-037 Reset mid-session aborts without a write strobe; words already written stay in memory.
REQ-038 A word partially assembled at reset is discarded.

Verification
REQ-039 Header 02 00 00 00, bytes 13 00 00 00 93 00 10 00 -> writes 0x00000013 @0x0 then 0x00100093 @0x4; done_o=1, words_written_o=2.
REQ-040 Header 00 00 00 00 -> DONE directly after the header; no wr_en pulse; done_o=1.
REQ-041 Header 01 04 00 00 (N=1025) -> ERROR; error_o=1, byte_ready_o=0, no writes.
REQ-042 N=1; byte_valid_i deasserted 3 cycles between each byte -> word written correctly; wr_en exactly 1 cycle after the 4th byte.
REQ-043 N=3; reset asserted after the 6th data byte -> only word 0 written; outputs 0 the next cycle; new start_i reloads from BASE_ADDR.
REQ-044 start_i pulsed while in DATA -> ignored; session completes normally.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: a little-endian word-count header followed by
// that many little-endian words, each written to consecutive word addresses from BASE_ADDR.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic [31:0] addr_imem_ram_o,
  output logic [31:0] wr_instr_imem_ram_o,
  output logic        wr_en_imem_ram_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [10:0] words_written_o,
  output logic [2:0]  dbg_state
);

  // Handshake: a byte moves on a rising edge where byte_valid_i and byte_ready_o are both 1;
  // the producer holds byte_data_i stable while valid is high and ready is low.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_q;
  logic [31:0] n_words;
  logic [31:2] addr_q;
  logic [31:0] instr_q;
  logic [10:0] ww_q;
  logic        in_rx;
  logic        take;
  logic        last_byte;
  logic [31:0] full_word;
  logic [10:0] ww_inc;

  assign in_rx     = (state == S_HDR) || (state == S_DATA);
  assign take      = byte_valid_i && in_rx;
  assign last_byte = take && (byte_cnt == 2'd3);
  // Only meaningful on the 4th byte: the top lane comes straight from the bus.
  assign full_word = {byte_data_i, asm_q};
  assign ww_inc    = ww_q + 11'd1;

  always_comb begin
    state_nxt        = state;
    byte_ready_o     = 1'b0;
    wr_en_imem_ram_o = 1'b0;
    busy_o           = 1'b0;
    done_o           = 1'b0;
    error_o          = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        done_o  = (state == S_DONE);
        error_o = (state == S_ERROR);
        if (start_i) state_nxt = S_HDR;
      end
      S_HDR: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (last_byte) begin
          if (full_word == 32'd0)     state_nxt = S_DONE;
          else if (full_word > MAX_N) state_nxt = S_ERROR;
          else                        state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (last_byte) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        wr_en_imem_ram_o = 1'b1;
        busy_o           = 1'b1;
        state_nxt        = ({21'd0, ww_inc} == n_words) ? S_DONE : S_DATA;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      byte_cnt <= 2'd0;
      asm_q    <= 24'd0;
      n_words  <= 32'd0;
      addr_q   <= BASE_ADDR[31:2];
      instr_q  <= 32'd0;
      ww_q     <= 11'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            byte_cnt <= 2'd0;
            asm_q    <= 24'd0;
            addr_q   <= BASE_ADDR[31:2];
            ww_q     <= 11'd0;
          end
        end
        S_HDR, S_DATA: begin
          if (take) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0:    asm_q[7:0]   <= byte_data_i;
              2'd1:    asm_q[15:8]  <= byte_data_i;
              2'd2:    asm_q[23:16] <= byte_data_i;
              default: ;
            endcase
          end
          if (last_byte && state == S_HDR)  n_words <= full_word;
          if (last_byte && state == S_DATA) instr_q <= full_word;
        end
        S_WRITE: begin
          addr_q <= addr_q + 30'd1;
          ww_q   <= ww_inc;
        end
        default: ;
      endcase
    end
  end

  assign addr_imem_ram_o     = {addr_q, 2'b00};
  assign wr_instr_imem_ram_o = instr_q;
  assign words_written_o     = ww_q;
  assign dbg_state           = state;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header/word streams with hand-computed write expectations.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  logic [31:0] addr_imem_ram_o;
  logic [31:0] wr_instr_imem_ram_o;
  logic        wr_en_imem_ram_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [10:0] words_written_o;
  logic [2:0]  dbg_state;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_DATA = 3'd2, ST_DONE = 3'd4, ST_ERROR = 3'd5;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_accept = 0;
  logic [63:0] exp_q[$];
  logic [63:0] wr_log[$];
  int          wr_cyc_q[$];

  imem_loader dut (
    .clk                 (clk),
    .reset               (reset),
    .start_i             (start_i),
    .byte_valid_i        (byte_valid_i),
    .byte_data_i         (byte_data_i),
    .byte_ready_o        (byte_ready_o),
    .addr_imem_ram_o     (addr_imem_ram_o),
    .wr_instr_imem_ram_o (wr_instr_imem_ram_o),
    .wr_en_imem_ram_o    (wr_en_imem_ram_o),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .error_o             (error_o),
    .words_written_o     (words_written_o),
    .dbg_state           (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // write monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (wr_en_imem_ram_o) begin
      wr_log.push_back({addr_imem_ram_o, wr_instr_imem_ram_o});
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks (all called at a falling edge)
  task automatic send_byte(input logic [7:0] b);
    int w;
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    w = 0;
    while (!byte_ready_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("byte_accept_timeout", 64'(w < 20), 64'd1);
    last_accept = cyc;
    @(negedge clk);
    byte_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] wd, input int gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(wd[8*i +: 8]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic start_session();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input string tag);
    int w;
    w = 0;
    while (dbg_state !== st && w < 50) begin
      @(negedge clk);
      w++;
    end
    check(tag, 64'(w < 50), 64'd1);
  endtask

  // scoreboard: compare logged writes against the expected queue, then clear both
  task automatic check_writes(input string tag);
    int n;
    check({tag, "_count"}, 64'(wr_log.size()), 64'(exp_q.size()));
    n = (wr_log.size() < exp_q.size()) ? wr_log.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_write"}, wr_log[i], exp_q[i]);
    exp_q.delete();
    wr_log.delete();
    wr_cyc_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    start_i = 1'b0;
    byte_valid_i = 1'b0;
    byte_data_i = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_flags", {60'd0, byte_ready_o, wr_en_imem_ram_o, busy_o, done_o}, 64'd0);
    check("rst_error", 64'(error_o), 64'd0);
    check("rst_addr_instr", {addr_imem_ram_o, wr_instr_imem_ram_o}, 64'd0);
    check("rst_words", 64'(words_written_o), 64'd0);

    // two-word program
    start_session();
    check("s1_busy_ready", {62'd0, busy_o, byte_ready_o}, 64'd3);
    send_word(32'd2, 0);
    send_word(32'h0000_0013, 0);
    send_word(32'h0010_0093, 0);
    wait_state(ST_DONE, "s1_done_timeout");
    check("s1_done", {61'd0, busy_o, done_o, error_o}, 64'b010);
    check("s1_words", 64'(words_written_o), 64'd2);
    exp_q.push_back({32'h0, 32'h0000_0013});
    exp_q.push_back({32'h4, 32'h0010_0093});
    check_writes("s1");

    // zero-length program
    start_session();
    send_word(32'd0, 0);
    check("s2_state", 64'(dbg_state), 64'(ST_DONE));
    check("s2_done", 64'(done_o), 64'd1);
    check("s2_words", 64'(words_written_o), 64'd0);
    check_writes("s2");

    // N = 1025 is one over the limit
    start_session();
    send_word(32'd1025, 0);
    check("s3_state", 64'(dbg_state), 64'(ST_ERROR));
    check("s3_flags", {61'd0, error_o, done_o, busy_o}, 64'b100);
    byte_valid_i = 1'b1;
    byte_data_i = 8'h55;
    repeat (3) @(negedge clk);
    check("s3_ready", 64'(byte_ready_o), 64'd0);
    byte_valid_i = 1'b0;
    check_writes("s3");

    // huge N whose low bits look small must still be rejected
    start_session();
    check("s3b_error_cleared", 64'(error_o), 64'd0);
    send_word(32'h0100_0001, 0);
    check("s3b_state", 64'(dbg_state), 64'(ST_ERROR));
    check_writes("s3b");

    // one word with 3-cycle valid gaps; strobe one cycle after the 4th byte
    start_session();
    send_word(32'd1, 3);
    send_byte(8'hEF); repeat (3) @(negedge clk);
    send_byte(8'hBE); repeat (3) @(negedge clk);
    send_byte(8'hAD); repeat (3) @(negedge clk);
    send_byte(8'hDE);
    wait_state(ST_DONE, "s4_done_timeout");
    check("s4_latency", 64'((wr_cyc_q.size() > 0) ? wr_cyc_q[0] - last_accept : -1), 64'd1);
    check("s4_words", 64'(words_written_o), 64'd1);
    exp_q.push_back({32'h0, 32'hDEAD_BEEF});
    check_writes("s4");

    // reset mid-word aborts the session
    start_session();
    send_word(32'd3, 0);
    send_word(32'h1122_3344, 0);
    send_byte(8'hA1);
    send_byte(8'hA2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("s5_state", 64'(dbg_state), 64'(ST_IDLE));
    check("s5_flags", {59'd0, byte_ready_o, wr_en_imem_ram_o, busy_o, done_o, error_o}, 64'd0);
    check("s5_addr_words", {21'd0, addr_imem_ram_o, words_written_o}, 64'd0);
    exp_q.push_back({32'h0, 32'h1122_3344});
    check_writes("s5");
    start_session();
    send_word(32'd1, 0);
    send_word(32'hCAFE_F00D, 0);
    wait_state(ST_DONE, "s5b_done_timeout");
    check("s5b_words", 64'(words_written_o), 64'd1);
    exp_q.push_back({32'h0, 32'hCAFE_F00D});
    check_writes("s5b");

    // start_i during DATA is ignored
    start_session();
    send_word(32'd2, 0);
    send_word(32'h1234_5678, 0);
    wait_state(ST_DATA, "s6_data_timeout");
    start_session();
    check("s6_state", 64'(dbg_state), 64'(ST_DATA));
    check("s6_mid_words", 64'(words_written_o), 64'd1);
    send_word(32'h9ABC_DEF0, 0);
    wait_state(ST_DONE, "s6_done_timeout");
    check("s6_words", 64'(words_written_o), 64'd2);
    exp_q.push_back({32'h0, 32'h1234_5678});
    exp_q.push_back({32'h4, 32'h9ABC_DEF0});
    check_writes("s6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
